uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer directly upstream of the UART transmitter. Accepts bytes from the command/response logic at any rate up to one per clock. Stores them in a synchronous FIFO and drains them one at a time into the transmitter through its tx_start / tx_data / tx_busy handshake. Producers never need to watch the transmitter's busy state.

---
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding the 8N1 UART transmitter.
// Producers write at up to one byte per clock; the sequencer drains one
// byte per frame through the tx_start / tx_data / tx_busy handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BUSY_WAIT_MAX = 4
) (
  input  logic                     clk_50mhz,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic                     launch_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                overflow_q, overflow_d;
  logic                launch_err_q, launch_err_d;
  logic                wr_acc;
  logic                pop;
  logic                wait_expired;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign launch_err   = launch_err_q;
  assign wait_expired = (wait_q == WW'(BUSY_WAIT_MAX - 1));

  // Sequencer state register
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state; flush forces IDLE regardless of the transmitter
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (!empty) state_d = WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_d = WAIT_DONE;
          end else if (wait_expired) begin
            state_d = IDLE;
          end
        end
        WAIT_DONE: if (!tx_busy) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Sequencer outputs: launch/pop from IDLE, busy-rise timeout in WAIT_BUSY
  always_comb begin
    pop          = 1'b0;
    tx_start_d   = 1'b0;
    launch_err_d = 1'b0;
    tx_data_d    = tx_data_q;
    wait_d       = wait_q;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = mem_q[rptr_q];
            wait_d     = '0;
          end
        end
        WAIT_BUSY: begin
          if (!tx_busy) begin
            if (wait_expired) begin
              launch_err_d = 1'b1;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO pointer/occupancy update; fullness is judged before any same-edge pop
  always_comb begin
    wr_acc     = wr_en && !full && !flush;
    overflow_d = wr_en && full && !flush;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (pop)    rptr_d = rptr_q + AW'(1);
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage array; no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk_50mhz) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      overflow_q   <= 1'b0;
      launch_err_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      overflow_q   <= overflow_d;
      launch_err_q <= launch_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural 8N1 transmitter whose
// busy flag rises two clocks after tx_start and lasts 10 bit periods.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HALF = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        launch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // transmitter model controls
  int unsigned bit_clks = 2;
  logic        hold_busy = 1'b0;
  logic        tx_dead = 1'b0;
  logic        start_d;
  logic        busy_r;
  int unsigned tx_cnt;
  int unsigned frames_done;

  logic [7:0]  sb_q[$];
  logic [7:0]  mon_d[$];
  int unsigned mon_c[$];
  int unsigned err_q[$];

  uart_tx_fifo #(
    .DEPTH(16),
    .DATA_W(8),
    .BUSY_WAIT_MAX(4)
  ) dut (
    .clk_50mhz (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .launch_err(launch_err)
  );

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = busy_r | hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d     <= 1'b0;
      busy_r      <= 1'b0;
      tx_cnt      <= 0;
      frames_done <= 0;
    end else begin
      start_d <= tx_start && !tx_dead;
      if (busy_r) begin
        if (tx_cnt == 1) begin
          busy_r      <= 1'b0;
          frames_done <= frames_done + 1;
        end
        tx_cnt <= tx_cnt - 1;
      end else if (start_d) begin
        busy_r <= 1'b1;
        tx_cnt <= 10 * bit_clks;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        mon_d.push_back(tx_data);
        mon_c.push_back(cyc);
      end
      if (launch_err) err_q.push_back(cyc);
    end
  end

  initial begin
    #(CLK_HALF * 2 * 80000);
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit acc, output int unsigned wcyc);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wcyc  = cyc;
    if (acc) sb_q.push_back(d);
  endtask

  task automatic expect_launch(input string tag, input int unsigned max_wait, output int unsigned lcyc);
    int unsigned n = 0;
    logic [7:0] exp_d;
    lcyc = 0;
    while (mon_d.size() == 0 && n < max_wait) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (mon_d.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed no tx_start within %0d cycles, expected one launch", tag, max_wait);
    end
    if (mon_d.size() != 0) begin
      lcyc = mon_c.pop_front();
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL %s: observed launch of %0h, expected no launch", tag, mon_d[0]);
      end
      exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
      check(tag, 32'(mon_d.pop_front()), 32'(exp_d));
    end
  endtask

  initial begin
    int unsigned wc, lc, lc_prev, pk, fd0, n, ec;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst count", 32'(count), 0);
    check("rst empty", 32'(empty), 1);
    check("rst full", 32'(full), 0);
    check("rst tx_start", 32'(tx_start), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst launch_err", 32'(launch_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // single byte
    bit_clks = 2;
    write_byte(8'h55, 1'b1, wc);
    check("t1 empty after write", 32'(empty), 0);
    check("t1 count after write", 32'(count), 1);
    expect_launch("t1 data", 50, lc);
    check("t1 launch latency", lc - wc, 1);
    wait_cycles(10 * bit_clks + 20);
    check("t1 count drained", 32'(count), 0);
    check("t1 empty drained", 32'(empty), 1);
    check("t1 tx_data held", 32'(tx_data), 32'h55);

    // burst at 115200 baud (434 clocks per bit)
    bit_clks = 434;
    pk = 0;
    for (int i = 0; i < 5; i++) begin
      write_byte(8'(i + 1), 1'b1, wc);
      if (32'(count) > pk) pk = 32'(count);
    end
    check("t2 count peak", pk, 4);
    lc_prev = 0;
    for (int i = 0; i < 5; i++) begin
      expect_launch("t2 burst data", 10 * bit_clks + 50, lc);
      if (i > 0) check("t2 launch spacing ok", 32'(lc - lc_prev >= 10 * bit_clks + 1), 1);
      lc_prev = lc;
    end
    wait_cycles(10 * bit_clks + 20);
    check("t2 empty", 32'(empty), 1);

    // full / overflow with transmitter held busy
    bit_clks  = 2;
    hold_busy = 1'b1;
    write_byte(8'h80, 1'b1, wc);
    expect_launch("t3 held launch", 50, lc);
    for (int i = 0; i < 18; i++) begin
      write_byte(8'(i), i < 16, wc);
      check("t3 overflow", 32'(overflow), 32'(i >= 16));
      check("t3 full", 32'(full), 32'(i >= 15));
    end
    check("t3 count full", 32'(count), 16);
    wait_cycles(1);
    check("t3 overflow cleared", 32'(overflow), 0);
    check("t3 no launch while busy", mon_d.size(), 0);
    hold_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_launch("t3 drain data", 10 * bit_clks + 50, lc);
    end
    wait_cycles(60);
    check("t3 dropped never sent", mon_d.size(), 0);
    check("t3 empty", 32'(empty), 1);

    // wrap-around
    bit_clks = 1;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      write_byte(8'(8'hA0 + i), 1'b1, wc);
      check("t4 count bound", 32'(count <= 5'd16), 1);
    end
    for (int i = 0; i < 40; i++) begin
      expect_launch("t4 wrap data", 10 * bit_clks + 50, lc);
    end
    wait_cycles(30);
    check("t4 empty", 32'(empty), 1);

    // missed start
    tx_dead = 1'b1;
    write_byte(8'h3C, 1'b1, wc);
    expect_launch("t5 launch", 50, lc);
    n = 0;
    while (err_q.size() == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5 launch_err seen", 32'(err_q.size() != 0), 1);
    if (err_q.size() != 0) begin
      ec = err_q.pop_front();
      check("t5 launch_err delay", ec - lc, 4);
    end
    check("t5 empty", 32'(empty), 1);
    write_byte(8'h3D, 1'b1, wc);
    expect_launch("t5 relaunch", 50, lc);
    check("t5 relaunch latency", lc - wc, 1);
    wait_cycles(10);
    check("t5 single err pulse", err_q.size(), 1);
    err_q.delete();
    tx_dead = 1'b0;

    // flush mid-operation
    bit_clks = 4;
    for (int i = 0; i < 6; i++) begin
      write_byte(8'(8'h61 + i), 1'b1, wc);
    end
    expect_launch("t6 first", 50, lc);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    fd0 = frames_done;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    check("t6 count flushed", 32'(count), 0);
    check("t6 empty flushed", 32'(empty), 1);
    check("t6 tx_data kept", 32'(tx_data), 32'h61);
    wait_cycles(10 * bit_clks + 20);
    check("t6 no launch after flush", mon_d.size(), 0);
    check("t6 frame completed", frames_done - fd0, 1);
    check("t6 busy dropped", 32'(tx_busy), 0);
    write_byte(8'h77, 1'b1, wc);
    expect_launch("t6 post-flush data", 50, lc);
    check("t6 post-flush latency", lc - wc, 1);
    wait_cycles(10 * bit_clks + 20);

    // reset mid-frame
    write_byte(8'h90, 1'b1, wc);
    write_byte(8'h91, 1'b1, wc);
    expect_launch("t7 first", 50, lc);
    wait_cycles(3);
    rst_n = 1'b0;
    #1;
    check("t7 count reset", 32'(count), 0);
    check("t7 tx_data reset", 32'(tx_data), 0);
    check("t7 busy reset", 32'(tx_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    wait_cycles(50);
    check("t7 no launch after reset", mon_d.size(), 0);
    check("t7 empty", 32'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
